// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose:
//   Generates the raster timing for a VGA-style display from one system
//   clock. A prescaler divides ClkPort down to the pixel rate. The horizontal
//   and vertical counters walk the line and the frame. Each line and each
//   frame runs in this order: active, front porch, sync, back porch.
//   Sync and bright are registered from the *next* counter values, so they
//   change on the same edge as hCount/vCount.
//   Motion logic runs on ClkPort, gated by frame_tick/move_tick, so no
//   derived clocks are needed.
//
// Optional feature:
//   `define VGA_TIMING_FRAME_CNT_EN to build the 16-bit frame counter and
//   the MOVE_FRAMES move divider. Without it, frame_count is 0 and move_tick
//   mirrors frame_tick.
//
// Ports:
//   ClkPort      in   system clock (single domain)
//   Reset        in   asynchronous, active-high reset
//   hSync        out  horizontal sync, SYNC_POL level during the sync region
//   vSync        out  vertical sync, SYNC_POL level during the sync region
//   bright       out  high inside the visible area
//   hCount       out  pixel index in the line, 0..H_TOTAL-1
//   vCount       out  line index in the frame, 0..V_TOTAL-1
//   pix_en       out  one-cycle pulse marking each pixel advance
//   frame_tick   out  one-cycle pulse when the frame wraps to (0,0)
//   move_tick    out  one-cycle pulse every MOVE_FRAMES frames
//   frame_count  out  frames since reset, modulo 2^16
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int PIX_DIV     = 4,
    parameter bit SYNC_POL    = 1'b0,
    parameter int CNT_W       = 10,
    parameter int MOVE_FRAMES = 1
) (
    input  logic             ClkPort,
    input  logic             Reset,
    output logic             hSync,
    output logic             vSync,
    output logic             bright,
    output logic [CNT_W-1:0] hCount,
    output logic [CNT_W-1:0] vCount,
    output logic             pix_en,
    output logic             frame_tick,
    output logic             move_tick,
    output logic [15:0]      frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [3:0]       PRESC_MAX = 4'(PIX_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);

    // Region bounds are compared one bit wider than the counters. An
    // exclusive end bound may then equal 2**CNT_W without wrapping.
    localparam logic [CNT_W:0] H_ACT_END  = (CNT_W+1)'(H_ACTIVE);
    localparam logic [CNT_W:0] H_SYNC_BEG = (CNT_W+1)'(H_ACTIVE + H_FP);
    localparam logic [CNT_W:0] H_SYNC_END = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W:0] V_ACT_END  = (CNT_W+1)'(V_ACTIVE);
    localparam logic [CNT_W:0] V_SYNC_BEG = (CNT_W+1)'(V_ACTIVE + V_FP);
    localparam logic [CNT_W:0] V_SYNC_END = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

    // The counters reset to (0,0), which lies in the visible area whenever
    // one exists.
    localparam bit BRIGHT_RST = (H_ACTIVE > 0) && (V_ACTIVE > 0);

    // Elaboration-time parameter checks
    if (PIX_DIV < 1 || PIX_DIV > 16) begin : g_bad_pix_div
        $error("vga_timing_gen: PIX_DIV must be in 1..16");
    end
    if (MOVE_FRAMES < 1 || MOVE_FRAMES > 255) begin : g_bad_move_frames
        $error("vga_timing_gen: MOVE_FRAMES must be in 1..255");
    end
    if ((H_TOTAL - 1) >= (2 ** CNT_W) || (V_TOTAL - 1) >= (2 ** CNT_W)) begin : g_bad_cnt_w
        $error("vga_timing_gen: CNT_W too narrow for H_TOTAL-1 / V_TOTAL-1");
    end

    logic [3:0]       presc_q;
    logic [CNT_W-1:0] h_q;
    logic [CNT_W-1:0] v_q;
    logic [CNT_W-1:0] h_nxt;
    logic [CNT_W-1:0] v_nxt;
    logic             frame_wrap;
    logic             h_in_sync;
    logic             v_in_sync;
    logic             in_active;
    logic             hsync_q;
    logic             vsync_q;
    logic             bright_q;
    logic             frame_tick_q;

    // pix_en comes straight from the prescaler. With PIX_DIV=1 it would be
    // stuck high, so it is also gated by Reset. This keeps it quiet while
    // the block is held in reset.
    assign pix_en = ~Reset & (presc_q == PRESC_MAX);

    always_comb begin
        h_nxt      = h_q;
        v_nxt      = v_q;
        frame_wrap = 1'b0;
        if (pix_en) begin
            if (h_q == H_LAST) begin
                h_nxt = '0;
                if (v_q == V_LAST) begin
                    v_nxt      = '0;
                    frame_wrap = 1'b1;
                end else begin
                    v_nxt = v_q + 1'b1;
                end
            end else begin
                h_nxt = h_q + 1'b1;
            end
        end
        h_in_sync = ({1'b0, h_nxt} >= H_SYNC_BEG) && ({1'b0, h_nxt} < H_SYNC_END);
        v_in_sync = ({1'b0, v_nxt} >= V_SYNC_BEG) && ({1'b0, v_nxt} < V_SYNC_END);
        in_active = ({1'b0, h_nxt} < H_ACT_END) && ({1'b0, v_nxt} < V_ACT_END);
    end

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            presc_q      <= 4'd0;
            h_q          <= '0;
            v_q          <= '0;
            hsync_q      <= ~SYNC_POL;
            vsync_q      <= ~SYNC_POL;
            bright_q     <= BRIGHT_RST;
            frame_tick_q <= 1'b0;
        end else begin
            presc_q      <= (presc_q == PRESC_MAX) ? 4'd0 : presc_q + 4'd1;
            h_q          <= h_nxt;
            v_q          <= v_nxt;
            hsync_q      <= h_in_sync ? SYNC_POL : ~SYNC_POL;
            vsync_q      <= v_in_sync ? SYNC_POL : ~SYNC_POL;
            bright_q     <= in_active;
            frame_tick_q <= frame_wrap;
        end
    end

    assign hCount     = h_q;
    assign vCount     = v_q;
    assign hSync      = hsync_q;
    assign vSync      = vsync_q;
    assign bright     = bright_q;
    assign frame_tick = frame_tick_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0]  move_cnt_q;
    logic        move_tick_q;
    logic [15:0] frame_cnt_q;

    // Both registers update on the same edge that raises frame_tick.
    // move_tick and the new frame_count are therefore visible in the
    // frame_tick cycle itself.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            move_cnt_q  <= 8'd0;
            move_tick_q <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            move_tick_q <= 1'b0;
            if (frame_wrap) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
                if (move_cnt_q == 8'(MOVE_FRAMES - 1)) begin
                    move_cnt_q  <= 8'd0;
                    move_tick_q <= 1'b1;
                end else begin
                    move_cnt_q <= move_cnt_q + 8'd1;
                end
            end
        end
    end

    assign move_tick   = move_tick_q;
    assign frame_count = frame_cnt_q;
`else
    assign move_tick   = frame_tick_q;
    assign frame_count = 16'd0;
`endif

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch, in pixels.
REQ-003 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch, in lines.
REQ-005 Parameter PIX_DIV, 4, ClkPort cycles per pixel; legal range 1..16.
REQ-006 Parameter SYNC_POL, 0, sync active level (0 = active-low).
REQ-007 Parameter CNT_W, 10, width of hCount and vCount.
REQ-008 Parameter MOVE_FRAMES, 1, frames per move_tick; legal range 1..255.
REQ-009 ClkPort  in  1  system clock; single clock domain.
REQ-010 Reset  in  1  asynchronous, active-high reset.
REQ-011 hSync  out  1  horizontal sync at SYNC_POL level during the sync region.
REQ-012 vSync  out  1  vertical sync at SYNC_POL level during the sync region.
REQ-013 bright  out  1  high while hCount < H_ACTIVE and vCount < V_ACTIVE.
REQ-014 hCount  out  CNT_W  pixel index in line, 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP.
REQ-015 vCount  out  CNT_W  line index in frame, 0..V_TOTAL-1, where V_TOTAL is defined the same way.
REQ-016 pix_en  out  1  one-ClkPort-cycle pulse marking each pixel advance.
REQ-017 frame_tick  out  1  one-cycle pulse at frame wrap.
REQ-018 move_tick  out  1  one-cycle pulse every MOVE_FRAMES frames; replaces derived clocks for object motion.
REQ-019 frame_count  out  16  frames since reset, modulo 2^16.

Function
REQ-020 Prescaler counts 0..PIX_DIV-1 and wraps; pix_en is asserted for exactly the cycle in which the prescaler equals PIX_DIV-1. With PIX_DIV=1, pix_en is held constantly high.
REQ-021 hCount increments on each pix_en; at H_TOTAL-1 it wraps to 0 and vCount advances.
REQ-022 vCount wraps from V_TOTAL-1 to 0 on the same pix_en on which hCount wraps.
REQ-023 Line layout: active region first (0..H_ACTIVE-1), then front porch, sync (H_ACTIVE+H_FP .. H_ACTIVE+H_FP+H_SYNC-1), then back porch. The frame uses the same ordering.
REQ-024 hSync, vSync and bright are registered and decoded from the next counter values, so they change on the same edge as hCount/vCount (zero skew).
REQ-025 frame_tick is asserted in the single cycle in which hCount and vCount both become 0 after a wrap; it is not asserted on exit from reset.
REQ-026 A move counter increments on frame_tick; when it reaches MOVE_FRAMES-1 it clears and pulses move_tick coincident with frame_tick. With MOVE_FRAMES=1, move_tick equals frame_tick.
REQ-027 frame_count increments on frame_tick and wraps from 0xFFFF to 0x0000.
REQ-028 Counter width rule: CNT_W must be large enough to hold H_TOTAL-1 and V_TOTAL-1; an elaboration-time check fails otherwise.

Reset
REQ-029 While Reset is high: prescaler, hCount, vCount, move counter and frame_count are 0; pix_en, frame_tick and move_tick are 0; bright is 1 when H_ACTIVE>0 and V_ACTIVE>0; hSync and vSync are at the inactive level (~SYNC_POL).
REQ-030 Reset asserted mid-frame clears all state asynchronously. The first pix_en occurs PIX_DIV cycles after Reset deasserts, and counting resumes from hCount=0, vCount=0.

Configuration
REQ-031 Macro VGA_TIMING_FRAME_CNT_EN. When defined: frame_count and the move counter are implemented per REQ-026/027. When undefined: frame_count is tied to 0, move_tick equals frame_tick, and MOVE_FRAMES is ignored.

Verification
REQ-032 Defaults, Reset released: pix_en every 4th cycle; hSync low for hCount 656..751, high elsewhere; line period 3200 ClkPort cycles.
REQ-033 Defaults: vSync low for vCount 490..491; frame_tick period 800*525*4 = 1,680,000 cycles; bright count per frame = 307,200 pix_en pulses.
REQ-034 MOVE_FRAMES=3 with macro defined: move_tick on frames 3, 6, 9; frame_count = 9 after the 9th frame_tick. With macro undefined: move_tick on every frame_tick and frame_count = 0.
REQ-035 Reset pulsed at hCount=300, vCount=200: all counters read 0 immediately; first pix_en 4 cycles after release; no frame_tick produced by the reset.
REQ-036 PIX_DIV=1, SYNC_POL=1, tiny timing 8/2/2/2 x 4/1/1/1: hSync high at hCount 10..11; frame period 98 cycles; pix_en constantly 1.
REQ-037 frame_count preloaded at 0xFFFF via force: the next frame_tick yields 0x0000.
